pht_upd_ctrl: RTL and testbench

PHT_UPD_CTRL -- requirements
Module: pht_upd_ctrl

---
 rtl/pht_upd_ctrl.sv | 103 ++++++++++
 tb/tb_pht_upd_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pht_upd_ctrl.sv
// PHT update controller: queues up to two retired branches per cycle, writes one per cycle, sweeps a full clear on request.
// Latency: a push reaches the PHT port two edges later; ret_rdy_o drops when fewer than two free slots or while busy clearing.
module pht_upd_ctrl #(
  parameter int LOG_INDEX  = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int LOG_DEPTH  = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 ret0_vld_i,
  input  logic [LOG_INDEX-1:0] ret0_index_i,
  input  logic                 ret0_dir_i,
  input  logic                 ret1_vld_i,
  input  logic [LOG_INDEX-1:0] ret1_index_i,
  input  logic                 ret1_dir_i,
  output logic                 ret_rdy_o,
  input  logic                 clr_req_i,
  output logic                 clr_busy_o,
  output logic                 pht_brdir_we_o,
  output logic [LOG_INDEX-1:0] pht_wt_index_o,
  output logic                 pht_brdir_o,
  output logic                 pht_clr_o,
  output logic [LOG_DEPTH:0]   fifo_cnt_o
);

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

  localparam logic [LOG_DEPTH:0] CNT_RDY_MAX = (LOG_DEPTH+1)'(FIFO_DEPTH - 2);

  state_t               state_q;
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d, wr_ptr1, rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]   cnt_q, cnt_d;
  logic [LOG_INDEX-1:0] sweep_q;
  logic                 we_q, clr_q, dir_q;
  logic [LOG_INDEX-1:0] idx_q;
  logic [LOG_INDEX:0]   mem_q [FIFO_DEPTH];
  logic [LOG_INDEX:0]   head;
  logic                 push0, push1, pop;

  assign ret_rdy_o      = (state_q == RUN) && (cnt_q <= CNT_RDY_MAX);
  assign clr_busy_o     = (state_q != RUN);
  assign pht_brdir_we_o = we_q;
  assign pht_clr_o      = clr_q;
  assign pht_wt_index_o = idx_q;
  assign pht_brdir_o    = dir_q;
  assign fifo_cnt_o     = cnt_q;
  assign head           = mem_q[rd_ptr_q];

  always_comb begin
    push0    = ret_rdy_o & ret0_vld_i;
    push1    = ret_rdy_o & ret1_vld_i;
    pop      = (state_q != CLEAR) && (cnt_q != '0);
    // slot 1 lands behind slot 0 only when slot 0 actually pushed
    wr_ptr1  = wr_ptr_q + LOG_DEPTH'(push0);
    wr_ptr_d = wr_ptr1 + LOG_DEPTH'(push1);
    rd_ptr_d = rd_ptr_q + LOG_DEPTH'(pop);
    cnt_d    = cnt_q + (LOG_DEPTH+1)'(push0) + (LOG_DEPTH+1)'(push1) - (LOG_DEPTH+1)'(pop);
  end

  always_ff @(posedge clock) begin
    if (push0) mem_q[wr_ptr_q] <= {ret0_dir_i, ret0_index_i};
    if (push1) mem_q[wr_ptr1]  <= {ret1_dir_i, ret1_index_i};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      sweep_q  <= '0;
      we_q     <= 1'b0;
      clr_q    <= 1'b0;
      idx_q    <= '0;
      dir_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      we_q     <= 1'b0;
      clr_q    <= 1'b0;
      if (pop) begin
        we_q  <= 1'b1;
        idx_q <= head[LOG_INDEX-1:0];
        dir_q <= head[LOG_INDEX];
      end
      case (state_q)
        RUN: if (clr_req_i) state_q <= DRAIN;
        DRAIN: if (cnt_q <= (LOG_DEPTH+1)'(1)) state_q <= CLEAR;
        CLEAR: begin
          we_q    <= 1'b1;
          clr_q   <= 1'b1;
          idx_q   <= sweep_q;
          dir_q   <= 1'b0;
          sweep_q <= sweep_q + LOG_INDEX'(1);
          if (&sweep_q) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pht_upd_ctrl.sv
// Bench for pht_upd_ctrl: directed vector table, clear/reset sequences, then random traffic against a queue model.
module tb_pht_upd_ctrl;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ret0_vld_i = 1'b0, ret0_dir_i = 1'b0, ret1_vld_i = 1'b0, ret1_dir_i = 1'b0;
  logic [9:0] ret0_index_i = '0, ret1_index_i = '0;
  logic       clr_req_i = 1'b0;
  logic       ret_rdy_o, clr_busy_o, pht_brdir_we_o, pht_brdir_o, pht_clr_o;
  logic [9:0] pht_wt_index_o;
  logic [2:0] fifo_cnt_o;

  always #5 clock = ~clock;

  pht_upd_ctrl #(.LOG_INDEX(10), .FIFO_DEPTH(4), .LOG_DEPTH(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .ret0_vld_i(ret0_vld_i), .ret0_index_i(ret0_index_i), .ret0_dir_i(ret0_dir_i),
    .ret1_vld_i(ret1_vld_i), .ret1_index_i(ret1_index_i), .ret1_dir_i(ret1_dir_i),
    .ret_rdy_o(ret_rdy_o), .clr_req_i(clr_req_i), .clr_busy_o(clr_busy_o),
    .pht_brdir_we_o(pht_brdir_we_o), .pht_wt_index_o(pht_wt_index_o),
    .pht_brdir_o(pht_brdir_o), .pht_clr_o(pht_clr_o), .fifo_cnt_o(fifo_cnt_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a queue of pending {dir,idx} updates plus a mode and sweep position.
  typedef enum {M_RUN, M_DRAIN, M_CLEAR} mmode_t;
  mmode_t      mm = M_RUN;
  logic [10:0] q[$];
  int          sw = 0;
  logic        e_we = 0, e_clr = 0, e_dir = 0;
  logic [9:0]  e_idx = '0;

  typedef struct {
    logic rst, v0; logic [9:0] i0; logic d0, v1; logic [9:0] i1; logic d1, cr;
    logic [17:0] exp;
  } vec_t;
  vec_t tbl[10];

  function automatic logic [17:0] pk(logic we, logic clr, logic [9:0] idx, logic dir,
                                     logic [2:0] cnt, logic rdy, logic busy);
    return {we, clr, idx, dir, cnt, rdy, busy};
  endfunction

  function automatic vec_t mk(logic rst, logic v0, logic [9:0] i0, logic d0, logic v1,
                              logic [9:0] i1, logic d1, logic cr, logic [17:0] exp);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.i0 = i0; v.d0 = d0; v.v1 = v1; v.i1 = i1; v.d1 = d1; v.cr = cr;
    v.exp = exp;
    return v;
  endfunction

  function automatic logic [17:0] dut_out();
    return pk(pht_brdir_we_o, pht_clr_o, pht_wt_index_o, pht_brdir_o, fifo_cnt_o, ret_rdy_o, clr_busy_o);
  endfunction

  function automatic logic [17:0] mdl_out();
    return pk(e_we, e_clr, e_idx, e_dir, 3'(q.size()), (mm == M_RUN) && (q.size() <= 2), mm != M_RUN);
  endfunction

  task automatic model_edge(input logic rst, input logic v0, input logic [9:0] i0, input logic d0,
                            input logic v1, input logic [9:0] i1, input logic d1, input logic cr);
    logic        room;
    logic [10:0] ent;
    if (!rst) begin
      q.delete(); mm = M_RUN; sw = 0;
      e_we = 0; e_clr = 0; e_idx = '0; e_dir = 0;
    end else begin
      room = (mm == M_RUN) && (4 - q.size() >= 2);
      e_we = 0; e_clr = 0;
      if (mm == M_CLEAR) begin
        e_we = 1; e_clr = 1; e_idx = 10'(sw); e_dir = 0; sw++;
      end else if (q.size() > 0) begin
        ent = q.pop_front(); e_we = 1; e_idx = ent[9:0]; e_dir = ent[10];
      end
      if (room && v0) q.push_back({d0, i0});
      if (room && v1) q.push_back({d1, i1});
      case (mm)
        M_RUN:   if (cr) mm = M_DRAIN;
        M_DRAIN: if (q.size() == 0) mm = M_CLEAR;
        default: if (sw == 1024) begin sw = 0; mm = M_RUN; end
      endcase
    end
  endtask

  task automatic drv(input logic rst, input logic v0, input logic [9:0] i0, input logic d0,
                     input logic v1, input logic [9:0] i1, input logic d1, input logic cr);
    reset_n = rst; ret0_vld_i = v0; ret0_index_i = i0; ret0_dir_i = d0;
    ret1_vld_i = v1; ret1_index_i = i1; ret1_dir_i = d1; clr_req_i = cr;
    @(posedge clock);
    model_edge(rst, v0, i0, d0, v1, i1, d1, cr);
    #1;
  endtask

  task automatic check(input string name, input logic [17:0] exp);
    n_vec++;
    if (dut_out() !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, dut_out(), exp, $time);
    end
  endtask

  task automatic chk_val(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic v0, input logic [9:0] i0, input logic d0,
                     input logic v1, input logic [9:0] i1, input logic d1, input logic cr,
                     input string name);
    drv(rst, v0, i0, d0, v1, i1, d1, cr);
    check(name, mdl_out());
  endtask

  logic cr, fired;
  int   clr_wr, max_cnt, saw_stall, k;

  initial begin
    // inputs..., expected {we, clr, idx, dir, cnt, rdy, busy} after the edge
    tbl[0] = mk(0, 0, 10'h000, 0, 0, 10'h000, 0, 0, pk(0, 0, 10'h000, 0, 3'd0, 1, 0));
    tbl[1] = mk(1, 1, 10'h155, 1, 0, 10'h000, 0, 0, pk(0, 0, 10'h000, 0, 3'd1, 1, 0));
    tbl[2] = mk(1, 0, 10'h000, 0, 0, 10'h000, 0, 0, pk(1, 0, 10'h155, 1, 3'd0, 1, 0));
    tbl[3] = mk(1, 0, 10'h000, 0, 0, 10'h000, 0, 0, pk(0, 0, 10'h155, 1, 3'd0, 1, 0));
    tbl[4] = mk(1, 1, 10'h001, 0, 1, 10'h3FF, 1, 0, pk(0, 0, 10'h155, 1, 3'd2, 1, 0));
    tbl[5] = mk(1, 0, 10'h000, 0, 0, 10'h000, 0, 0, pk(1, 0, 10'h001, 0, 3'd1, 1, 0));
    tbl[6] = mk(1, 0, 10'h000, 0, 0, 10'h000, 0, 0, pk(1, 0, 10'h3FF, 1, 3'd0, 1, 0));
    tbl[7] = mk(1, 0, 10'h000, 0, 0, 10'h000, 0, 0, pk(0, 0, 10'h3FF, 1, 3'd0, 1, 0));
    tbl[8] = mk(1, 0, 10'h2C3, 1, 1, 10'h0AA, 0, 0, pk(0, 0, 10'h3FF, 1, 3'd1, 1, 0));
    tbl[9] = mk(1, 0, 10'h000, 0, 0, 10'h000, 0, 0, pk(1, 0, 10'h0AA, 0, 3'd0, 1, 0));

    for (int i = 0; i < 10; i++) begin
      drv(tbl[i].rst, tbl[i].v0, tbl[i].i0, tbl[i].d0, tbl[i].v1, tbl[i].i1, tbl[i].d1, tbl[i].cr);
      check($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // Two pushes attempted every cycle: queue saturates at 3 and stalls retire.
    max_cnt = 0; saw_stall = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 10'(2*i), i[0], 1, 10'(2*i+1), ~i[0], 0, "bp_push");
      if (int'(fifo_cnt_o) > max_cnt) max_cnt = int'(fifo_cnt_o);
      if (!ret_rdy_o) saw_stall = 1;
    end
    for (int i = 0; i < 5; i++) cyc(1, 0, '0, 0, 0, '0, 0, 0, "bp_drain");
    chk_val("bp_max_cnt", max_cnt, 3);
    chk_val("bp_stall", saw_stall, 1);

    // Clear with three pending entries; a second request mid-sweep must be ignored.
    cyc(1, 1, 10'h010, 1, 1, 10'h011, 0, 0, "clr_fill");
    cyc(1, 1, 10'h012, 1, 1, 10'h013, 1, 0, "clr_fill");
    cyc(1, 0, '0, 0, 0, '0, 0, 1, "clr_req");
    clr_wr = 0; fired = 0;
    for (k = 0; k < 1200 && mm != M_RUN; k++) begin
      cr = (mm == M_CLEAR) && (sw == 500) && !fired;
      if (cr) fired = 1;
      cyc(1, 1, 10'h3AB, 1, 1, 10'h0CD, 0, cr, "clr_sweep");
      if (pht_brdir_we_o && pht_clr_o) clr_wr++;
    end
    chk_val("clr_write_count", clr_wr, 1024);
    chk_val("clr_done_busy_rdy", {clr_busy_o, ret_rdy_o}, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, '0, 0, 0, '0, 0, 0, "clr_after");

    // Reset while the sweep sits at index 200.
    cyc(1, 0, '0, 0, 0, '0, 0, 1, "clr2_req");
    for (k = 0; k < 400 && !(mm == M_CLEAR && sw == 200); k++)
      cyc(1, 0, '0, 0, 0, '0, 0, 0, "clr2_sweep");
    chk_val("clr2_reach_200", pht_wt_index_o, 199);
    cyc(0, 0, '0, 0, 0, '0, 0, 0, "rst_mid_clear");
    chk_val("rst_we_busy_cnt_rdy", {pht_brdir_we_o, clr_busy_o, fifo_cnt_o, ret_rdy_o}, 1);
    cyc(1, 1, 10'h077, 1, 0, '0, 0, 0, "post_rst_push");
    cyc(1, 0, '0, 0, 0, '0, 0, 0, "post_rst_write");

    // Random traffic, occasional clears and resets.
    for (int i = 0; i < 2500; i++) begin
      cyc(($urandom_range(0, 999) != 0), 1'($urandom), 10'($urandom), 1'($urandom),
          1'($urandom), 10'($urandom), 1'($urandom), ($urandom_range(0, 299) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
